fc_pingpong_bank_buff: RTL

//  Double-buffered, multi-bank FC activation buffer. The producer streams one DATA_WIDTH element/cycle.
//  The FC array reads BAND_WIDTH elements/cycle in parallel, one per lane.
//  Two halves (ping/pong): writer fills one half while reader drains the other; halves swap on commit/release.

---
 rtl/fc_pingpong_bank_buff.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fc_pingpong_bank_buff.sv
// Double-buffered multi-bank activation buffer between the flatten stage and the FC array.
// The producer fills one half element by element while the FC array reads BAND_WIDTH lanes per row from the other half.
module fc_pingpong_bank_buff #(
    parameter int SRAM_DEPTH = 1024,
    parameter int BAND_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CAP        = BAND_WIDTH * SRAM_DEPTH,
    parameter int AW         = $clog2(SRAM_DEPTH),
    parameter int CW         = $clog2(CAP + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             wr_last,
    output logic [CW-1:0]                    wr_count,
    output logic                             rd_avail,
    input  logic                             rd_en,
    input  logic [AW-1:0]                    rd_addr,
    input  logic                             rd_done,
    output logic                             rd_valid,
    output logic [BAND_WIDTH*DATA_WIDTH-1:0] rd_data
);

    localparam int LW = (BAND_WIDTH > 1) ? $clog2(BAND_WIDTH) : 1;

    typedef enum logic [1:0] {
        H_EMPTY   = 2'd0,
        H_FILLING = 2'd1,
        H_FULL    = 2'd2
    } half_state_t;

    half_state_t       half_state_r   [2];
    half_state_t       half_state_nxt [2];
    logic [CW-1:0]     len_r          [2];
    logic [CW-1:0]     len_nxt        [2];
    logic [CW-1:0]     wr_count_r;
    logic [CW-1:0]     wr_count_nxt;
    logic              wr_sel_r;
    logic              wr_sel_nxt;
    logic              rd_sel_r;
    logic              rd_sel_nxt;
    logic              rd_valid_r;

    logic              wr_accept_s;
    logic              commit_s;
    logic              rd_fire_s;
    logic              rd_release_s;
    logic [LW-1:0]     wr_lane_s;
    logic [AW-1:0]     wr_row_s;
    logic [AW:0]       wr_mem_addr_s;
    logic [AW:0]       rd_mem_addr_s;
    logic [CW-1:0]     rd_base_s;
    logic [CW-1:0]     rd_len_s;

    // Handshake outputs are forced low while reset is asserted, even before state has settled.
    assign wr_ready     = !rst && (half_state_r[wr_sel_r] != H_FULL);
    assign rd_avail     = !rst && (half_state_r[rd_sel_r] == H_FULL);
    assign wr_accept_s  = wr_valid && wr_ready;
    assign commit_s     = wr_accept_s && (wr_last || (wr_count_r == CW'(CAP - 1)));
    assign rd_fire_s    = rd_en && rd_avail;
    assign rd_release_s = rd_done && rd_avail;

    assign wr_count = wr_count_r;
    assign rd_valid = rd_valid_r;

    assign wr_lane_s     = LW'(wr_count_r % CW'(BAND_WIDTH));
    assign wr_row_s      = AW'(wr_count_r / CW'(BAND_WIDTH));
    assign wr_mem_addr_s = {wr_sel_r, wr_row_s};
    assign rd_mem_addr_s = {rd_sel_r, rd_addr};
    assign rd_base_s     = CW'(rd_addr) * CW'(BAND_WIDTH);
    assign rd_len_s      = len_r[rd_sel_r];

    // Next-state for both halves, write pointer and read pointer.
    always_comb begin
        half_state_nxt = half_state_r;
        len_nxt        = len_r;
        wr_count_nxt   = wr_count_r;
        wr_sel_nxt     = wr_sel_r;
        rd_sel_nxt     = rd_sel_r;
        if (wr_accept_s) begin
            if (commit_s) begin
                half_state_nxt[wr_sel_r] = H_FULL;
                len_nxt[wr_sel_r]        = wr_count_r + CW'(1);
                wr_count_nxt             = {CW{1'b0}};
                wr_sel_nxt               = ~wr_sel_r;
            end else begin
                half_state_nxt[wr_sel_r] = H_FILLING;
                wr_count_nxt             = wr_count_r + CW'(1);
            end
        end else begin
            wr_count_nxt = wr_count_r;
        end
        // A half being released is FULL, so it can never be the one just committed.
        if (rd_release_s) begin
            half_state_nxt[rd_sel_r] = H_EMPTY;
            rd_sel_nxt               = ~rd_sel_r;
        end else begin
            rd_sel_nxt = rd_sel_r;
        end
    end

    // State register for halves, lengths and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            half_state_r[0] <= H_EMPTY;
            half_state_r[1] <= H_EMPTY;
            len_r[0]        <= {CW{1'b0}};
            len_r[1]        <= {CW{1'b0}};
            wr_count_r      <= {CW{1'b0}};
            wr_sel_r        <= 1'b0;
            rd_sel_r        <= 1'b0;
        end else begin
            half_state_r <= half_state_nxt;
            len_r        <= len_nxt;
            wr_count_r   <= wr_count_nxt;
            wr_sel_r     <= wr_sel_nxt;
            rd_sel_r     <= rd_sel_nxt;
        end
    end

    // Read-valid flag, squashed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_fire_s;
        end
    end

    for (genvar k = 0; k < BAND_WIDTH; k++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [2*SRAM_DEPTH];
        logic [DATA_WIDTH-1:0] lane_r;
        logic                  lane_we_s;
        logic                  lane_ok_s;

        assign lane_we_s = wr_accept_s && (wr_lane_s == LW'(k));
        assign lane_ok_s = (rd_base_s + CW'(k)) < rd_len_s;

        // Bank write port; the half is selected by the address MSB.
        always_ff @(posedge clk) begin
            if (lane_we_s) begin
                mem[wr_mem_addr_s] <= wr_data;
            end
        end

        // Registered read; lanes at or beyond the committed length return zero.
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_r <= {DATA_WIDTH{1'b0}};
            end else if (rd_fire_s && lane_ok_s) begin
                lane_r <= mem[rd_mem_addr_s];
            end else begin
                lane_r <= {DATA_WIDTH{1'b0}};
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_r;
    end

endmodule
